bf16_add_arbiter: RTL and testbench

- Shares one combinational bf16 adder between NUM_REQ independent requesters.
- Each requester offers an operand pair {a, b}. A round-robin arbiter grants one pair per cycle and drives it onto the adder.
- The adder sum is captured in a one-deep registered result stage, tagged with the requester ID, and released over a valid/ready handshake.
- Sits between the mul-node datapath lanes and the single bf16 adder instance. Also provides a saturating operation counter for utilisation profiling.

---
 rtl/bf16_add_arbiter_if.sv | 33 +++
 rtl/bf16_add_arbiter.sv | 99 +++++++++
 tb/tb_bf16_add_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bf16_add_arbiter_if.sv
// Bus bundle between requesters, the shared bf16 adder and the result consumer.
// The slave modport is the arbiter's view; master is the surrounding datapath.
interface bf16_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_vld;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*16-1:0] req_b;
  logic [NUM_REQ-1:0]    req_rdy;

  logic [15:0]           add_a;
  logic                  add_a_vld;
  logic [15:0]           add_b;
  logic                  add_b_vld;
  logic [15:0]           add_z;
  logic                  add_z_vld;

  logic                  res_vld;
  logic [15:0]           res_z;
  logic [ID_W-1:0]       res_id;
  logic                  res_rdy;

  modport slave (
    input  req_vld, req_a, req_b, add_z, add_z_vld, res_rdy,
    output req_rdy, add_a, add_a_vld, add_b, add_b_vld, res_vld, res_z, res_id
  );

  modport master (
    output req_vld, req_a, req_b, add_z, add_z_vld, res_rdy,
    input  req_rdy, add_a, add_a_vld, add_b, add_b_vld, res_vld, res_z, res_id
  );
endinterface

// File: rtl/bf16_add_arbiter.sv
// Round-robin sharing of one combinational bf16 adder between NUM_REQ lanes,
// with a one-deep tagged result register and a saturating utilisation counter.
module bf16_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  bf16_add_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]   op_cnt,
  output logic               err_zvld
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] scan_idx;
  logic            grant_any;
  logic            can_issue;
  logic [15:0]     res_z;
  logic [ID_W-1:0] res_id;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    can_issue     = !rst && ((state == EMPTY) || bus.res_rdy);
    grant_any     = 1'b0;
    grant_idx     = '0;
    scan_idx      = '0;
    state_nxt     = state;
    bus.req_rdy   = '0;
    bus.add_a     = '0;
    bus.add_b     = '0;

    // Scan from rr_ptr upward with wrap; the first pending lane wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (can_issue && !grant_any && bus.req_vld[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end

    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_any && (grant_idx == ID_W'(k))) begin
        bus.req_rdy[k] = 1'b1;
        bus.add_a      = bus.req_a[16*k +: 16];
        bus.add_b      = bus.req_b[16*k +: 16];
      end
    end

    // A grant refills the register even while it drains, so there is no bubble.
    if (grant_any) begin
      state_nxt = FULL;
    end else if ((state == FULL) && bus.res_rdy) begin
      state_nxt = EMPTY;
    end
  end

  assign bus.add_a_vld = grant_any;
  assign bus.add_b_vld = grant_any;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      res_z    <= '0;
      res_id   <= '0;
      op_cnt   <= '0;
      err_zvld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        res_z  <= bus.add_z;
        res_id <= grant_idx;
        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        if (op_cnt != '1) begin
          op_cnt <= op_cnt + 1'b1;
        end
        // The sum is still captured; the flag only records the protocol slip.
        if (!bus.add_z_vld) begin
          err_zvld <= 1'b1;
        end
      end
    end
  end

  assign bus.res_vld = (state == FULL);
  assign bus.res_z   = res_z;
  assign bus.res_id  = res_id;

endmodule

// File: tb/tb_bf16_add_arbiter.sv
// Bench for bf16_add_arbiter: behavioural bf16 adder, reference arbiter model,
// and a result scoreboard fed at grant time and drained at capture time.
module tb_bf16_add_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] op_cnt;
  logic err_zvld;
  logic zvld;
  logic [15:0] op_a [NUM_REQ];
  logic [15:0] op_b [NUM_REQ];

  always #5 clk = ~clk;

  bf16_add_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  bf16_add_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_cnt   (op_cnt),
    .err_zvld (err_zvld)
  );

  function automatic real bf_to_real(input logic [15:0] x);
    logic [63:0] bits;
    if (x[14:0] == 15'd0) return 0.0;
    bits = {x[15], 11'(int'(x[14:7]) + 896), x[6:0], 45'd0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [15:0] real_to_bf(input real r);
    logic [63:0] bits;
    if (r == 0.0) return 16'h0000;
    bits = $realtobits(r);
    return {bits[63], 8'(int'(bits[62:52]) - 896), bits[51:45]};
  endfunction

  function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
    return real_to_bf(bf_to_real(a) + bf_to_real(b));
  endfunction

  function automatic logic [15:0] rand_bf();
    return {1'($urandom), 8'($urandom_range(150, 100)), 7'($urandom)};
  endfunction

  // Shared adder stand-in and operand packing.
  always_comb bus.add_z = bf_add(bus.add_a, bus.add_b);
  assign bus.add_z_vld = zvld;
  always_comb begin
    bus.req_a = '0;
    bus.req_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.req_a[16*k +: 16] = op_a[k];
      bus.req_b[16*k +: 16] = op_b[k];
    end
  end

  typedef struct packed {
    logic [15:0]     z;
    logic [ID_W-1:0] id;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] z;
  } vec_t;
  vec_t tbl[6];

  logic            m_full = 1'b0;
  int              m_ptr  = 0;
  int              m_cnt  = 0;
  logic            m_err  = 1'b0;
  logic [15:0]     m_z    = '0;
  logic [ID_W-1:0] m_id   = '0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: drive at edge+1, check combinational grant mid-cycle, then
  // check registered state one step after the next edge.
  task automatic cycle(input logic [NUM_REQ-1:0] vld, input logic rdy,
                       input logic zv, input logic r);
    logic issue;
    int g;
    logic [NUM_REQ-1:0] exp_rdy;
    exp_t e;
    rst = r;
    bus.req_vld = vld;
    bus.res_rdy = rdy;
    zvld = zv;
    #4;
    issue = !r && (!m_full || rdy);
    g = -1;
    if (issue) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (g < 0 && vld[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
    check("add_vld", {30'd0, bus.add_a_vld, bus.add_b_vld}, (g >= 0) ? 32'd3 : 32'd0);
    if (g >= 0) begin
      check("add_a", 32'(bus.add_a), 32'(op_a[g]));
      check("add_b", 32'(bus.add_b), 32'(op_b[g]));
      sb.push_back('{z: bf_add(op_a[g], op_b[g]), id: ID_W'(g)});
    end else begin
      check("add_a_idle", 32'(bus.add_a), 32'd0);
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_full = 1'b0; m_ptr = 0; m_cnt = 0; m_err = 1'b0; m_z = '0; m_id = '0;
      sb.delete();
    end else if (g >= 0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard at %0t: got capture expected queued entry", $time);
      end else begin
        e = sb.pop_front();
        m_z = e.z;
        m_id = e.id;
      end
      m_full = 1'b1;
      m_ptr = (g + 1) % NUM_REQ;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (!zv) m_err = 1'b1;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    check("res_vld", 32'(bus.res_vld), 32'(m_full));
    check("res_z", 32'(bus.res_z), 32'(m_z));
    check("res_id", 32'(bus.res_id), 32'(m_id));
    check("op_cnt", 32'(op_cnt), 32'(m_cnt));
    check("err_zvld", 32'(err_zvld), 32'(m_err));
  endtask

  initial begin
    tbl[0] = '{idx: 1, a: 16'h3F80, b: 16'h4000, z: 16'h4040};
    tbl[1] = '{idx: 0, a: 16'h3F80, b: 16'h3F80, z: 16'h4000};
    tbl[2] = '{idx: 3, a: 16'h4000, b: 16'hC000, z: 16'h0000};
    tbl[3] = '{idx: 2, a: 16'h4040, b: 16'h3F80, z: 16'h4080};
    tbl[4] = '{idx: 1, a: 16'h3F00, b: 16'h3F00, z: 16'h3F80};
    tbl[5] = '{idx: 3, a: 16'hC040, b: 16'h3F80, z: 16'hC000};

    for (int k = 0; k < NUM_REQ; k++) begin
      op_a[k] = 16'h0000;
      op_b[k] = 16'h0000;
    end
    rst = 1'b1;
    bus.req_vld = '0;
    bus.res_rdy = 1'b0;
    zvld = 1'b1;
    @(posedge clk);
    #1;

    // Reset with requests pending: no grant, then a quiet idle stretch.
    cycle(4'b1111, 1'b1, 1'b1, 1'b1);
    cycle(4'b1111, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(4'b0000, 1'b1, 1'b1, 1'b0);

    // Single-requester adds with hand-computed sums.
    foreach (tbl[i]) begin
      op_a[tbl[i].idx] = tbl[i].a;
      op_b[tbl[i].idx] = tbl[i].b;
      cycle(4'(1 << tbl[i].idx), 1'b1, 1'b1, 1'b0);
      check("tbl_z", 32'(bus.res_z), 32'(tbl[i].z));
      check("tbl_id", 32'(bus.res_id), 32'(tbl[i].idx));
      cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    end

    // Round robin from a fresh pointer: ids 0,1,2,3,0 back to back.
    cycle(4'b0000, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < NUM_REQ; k++) begin
      op_a[k] = rand_bf();
      op_b[k] = rand_bf();
    end
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1, 1'b1, 1'b0);
      check("rr_id", 32'(bus.res_id), 32'(i % NUM_REQ));
    end
    check("rr_cnt", 32'(op_cnt), 32'd5);

    // Backpressure for 10 cycles, then drain plus same-cycle grant.
    for (int i = 0; i < 10; i++) cycle(4'b1111, 1'b0, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b1, 1'b0);
    check("bp_resume_id", 32'(bus.res_id), 32'd1);

    // Reset while full with requests pending; lowest pending index wins after.
    cycle(4'b1100, 1'b0, 1'b1, 1'b0);
    cycle(4'b1100, 1'b0, 1'b1, 1'b1);
    cycle(4'b1100, 1'b1, 1'b1, 1'b0);
    check("post_rst_id", 32'(bus.res_id), 32'd2);

    // Counter saturation with one unqualified adder result in the run.
    cycle(4'b0000, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(4'b1111, 1'b1, (i != 7), 1'b0);
    check("cnt_sat", 32'(op_cnt), 32'(CNT_MAX));
    check("err_set", 32'(err_zvld), 32'd1);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 1'b1, 1'b0);
    check("err_sticky", 32'(err_zvld), 32'd1);
    cycle(4'b0000, 1'b1, 1'b1, 1'b1);
    check("err_clr", 32'(err_zvld), 32'd0);

    // Random traffic and backpressure.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        op_a[k] = rand_bf();
        op_b[k] = rand_bf();
      end
      cycle(4'($urandom), 1'($urandom_range(3, 0) != 0), 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
